// File: rtl/vga_pixel_fetch.sv
// Framebuffer prefetcher: streams RAM words at fixed read latency into a small
// FIFO so the VGA timing stage can pop one pixel word per active clock.
module vga_pixel_fetch #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int ADDR_W     = 19,
    parameter int DEPTH      = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pix_req,
    output logic [15:0]       q,
    output logic              q_valid,
    output logic              underflow,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    input  logic [15:0]       mem_q
);

    localparam int DATA_W = 16;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [CNT_W:0]    CREDIT_MAX = (CNT_W + 1)'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state, state_nxt;
    logic [RD_LATENCY-1:0]   rd_vld_p;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        inflight;
    logic [CNT_W:0]          credit;
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [DATA_W-1:0]       fifo [DEPTH];
    logic                    wr_en, pop_ok, pop_empty;

    function automatic logic [CNT_W-1:0] ones(input logic [RD_LATENCY-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            n = n + CNT_W'(v[i]);
        return n;
    endfunction

    always_comb begin
        state_nxt = state;
        if (frame_start)
            state_nxt = RUN;
        inflight  = ones(rd_vld_p);
        credit    = {1'b0, count} + {1'b0, inflight};
        // Credit covers reads still in the RAM pipe, so a return always has a free slot.
        mem_rden  = (state == RUN) && !frame_start && (credit < CREDIT_MAX);
        wr_en     = rd_vld_p[RD_LATENCY-1] && !frame_start;
        pop_ok    = pix_req && !frame_start && (count != '0);
        pop_empty = pix_req && !frame_start && (count == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rd_vld_p  <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_addr  <= '0;
            q         <= '0;
            q_valid   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state <= state_nxt;
            // Return-tracking stage: a restart drops every pending return.
            if (frame_start) begin
                rd_vld_p <= '0;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                mem_addr <= '0;
            end else begin
                rd_vld_p <= (rd_vld_p << 1) | RD_LATENCY'(mem_rden);
                case ({wr_en, pop_ok})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (wr_en)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok)
                    rd_ptr <= rd_ptr + 1'b1;
                if (mem_rden)
                    mem_addr <= (mem_addr == LAST_ADDR) ? '0 : mem_addr + 1'b1;
            end
            // Output stage
            if (frame_start) begin
                q       <= '0;
                q_valid <= 1'b0;
            end else if (pop_ok) begin
                q       <= fifo[rd_ptr];
                q_valid <= 1'b1;
            end else if (pop_empty) begin
                q         <= '0;
                q_valid   <= 1'b1;
                underflow <= 1'b1;
            end else begin
                q_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en)
            fifo[wr_ptr] <= mem_q;
    end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: full-size instance plus a 4x2 instance for
// frame-wrap, each fed by a latency-2 RAM model holding mem[a] = a[15:0].
module tb_vga_pixel_fetch;

    localparam int ADDR_W = 19;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              fs1 = 1'b0, req1 = 1'b0, fs2 = 1'b0, req2 = 1'b0;
    logic [15:0]       q1, q2, mq1, mq2;
    logic              qv1, qv2, uf1, uf2, rden1, rden2;
    logic [ADDR_W-1:0] addr1, addr2;
    logic [15:0]       r1a, r1b, r2a, r2b;

    always #5 clock = ~clock;

    vga_pixel_fetch dut1 (
        .clock(clock), .reset(reset), .frame_start(fs1), .pix_req(req1),
        .q(q1), .q_valid(qv1), .underflow(uf1),
        .mem_addr(addr1), .mem_rden(rden1), .mem_q(mq1)
    );

    vga_pixel_fetch #(.WIDTH(4), .HEIGHT(2)) dut2 (
        .clock(clock), .reset(reset), .frame_start(fs2), .pix_req(req2),
        .q(q2), .q_valid(qv2), .underflow(uf2),
        .mem_addr(addr2), .mem_rden(rden2), .mem_q(mq2)
    );

    // Two-stage synchronous RAM; junk when not read so stray writes are visible.
    always @(posedge clock) begin
        r1a <= rden1 ? addr1[15:0] : 16'hDEAD;
        r1b <= r1a;
        r2a <= rden2 ? addr2[15:0] : 16'hDEAD;
        r2b <= r2a;
    end
    assign mq1 = r1b;
    assign mq2 = r2b;

    typedef struct packed {
        logic        v;
        logic [15:0] d;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   nwords[2] = '{640 * 480, 8};
    int   exp_addr[2], exp_word[2], issues[2];
    logic exp_uf[2];
    logic [15:0] q_last[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            exp_addr[i] = 0;
            exp_word[i] = 0;
            issues[i]   = 0;
            exp_uf[i]   = 1'b0;
            q_last[i]   = 16'h0;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        req1 = 1'b0; fs1 = 1'b0; req2 = 1'b0; fs2 = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_q", {16'h0, q1}, 32'h0);
        chk("rst_qv", {31'h0, qv1}, 32'h0);
        chk("rst_uf", {31'h0, uf1}, 32'h0);
        chk("rst_addr", {13'h0, addr1}, 32'h0);
        chk("rst_rden", {31'h0, rden1}, 32'h0);
        chk("rst_rden2", {31'h0, rden2}, 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        clear_model();
    endtask

    // One clock: drive, check the issue side, push expectation, check the pop side.
    task automatic cyc(input int sel, input bit req, input bit fs, input bit empty);
        logic              rden;
        logic [ADDR_W-1:0] addr;
        exp_t              e;
        @(negedge clock);
        req1 = (sel == 0) ? req : 1'b0;
        fs1  = (sel == 0) ? fs  : 1'b0;
        req2 = (sel == 1) ? req : 1'b0;
        fs2  = (sel == 1) ? fs  : 1'b0;
        #1;
        rden = (sel == 0) ? rden1 : rden2;
        addr = (sel == 0) ? addr1 : addr2;
        if (fs) begin
            chk("rden_on_fs", {31'h0, rden}, 32'h0);
            exp_addr[sel] = 0;
        end else if (rden) begin
            chk("mem_addr", {13'h0, addr}, exp_addr[sel]);
            issues[sel]++;
            exp_addr[sel] = (exp_addr[sel] + 1 == nwords[sel]) ? 0 : exp_addr[sel] + 1;
        end
        if (fs) begin
            sb.push_back('{v: 1'b0, d: 16'h0});
            q_last[sel]   = 16'h0;
            exp_word[sel] = 0;
        end else if (req && empty) begin
            sb.push_back('{v: 1'b1, d: 16'h0});
            q_last[sel] = 16'h0;
            exp_uf[sel] = 1'b1;
        end else if (req) begin
            sb.push_back('{v: 1'b1, d: exp_word[sel][15:0]});
            q_last[sel]   = exp_word[sel][15:0];
            exp_word[sel] = (exp_word[sel] + 1 == nwords[sel]) ? 0 : exp_word[sel] + 1;
        end else begin
            sb.push_back('{v: 1'b0, d: q_last[sel]});
        end
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk("q_valid", {31'h0, (sel == 0) ? qv1 : qv2}, {31'h0, e.v});
        chk("q", {16'h0, (sel == 0) ? q1 : q2}, {16'h0, e.d});
        chk("underflow", {31'h0, (sel == 0) ? uf1 : uf2}, {31'h0, exp_uf[sel]});
    endtask

    task automatic idle(input int sel, input int n);
        for (int i = 0; i < n; i++) cyc(sel, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pops(input int sel, input int n);
        for (int i = 0; i < n; i++) cyc(sel, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        clear_model();
        do_reset();

        // Frame wrap on the 4x2 instance: fill, then stream three frames' worth.
        cyc(1, 1'b0, 1'b1, 1'b0);
        idle(1, 20);
        chk("fill_issues_small", issues[1], 16);
        pops(1, 24);

        // Initial fill: exactly DEPTH reads, then issue stops.
        cyc(0, 1'b0, 1'b1, 1'b0);
        idle(0, 25);
        chk("fill_issues", issues[0], 16);
        pops(0, 640);
        idle(0, 3);

        // Restart, pop 0..9, then frame_start with a colliding request.
        cyc(0, 1'b0, 1'b1, 1'b0);
        idle(0, 3);
        pops(0, 10);
        cyc(0, 1'b1, 1'b1, 1'b0);
        idle(0, 3);
        pops(0, 5);
        idle(0, 2);

        // Request right after restart hits an empty FIFO; underflow is sticky.
        cyc(0, 1'b0, 1'b1, 1'b0);
        cyc(0, 1'b1, 1'b0, 1'b1);
        idle(0, 3);
        cyc(0, 1'b0, 1'b1, 1'b0);
        idle(0, 3);
        cyc(0, 1'b0, 1'b1, 1'b0);
        idle(0, 2);

        // Asynchronous reset while reads are in flight.
        cyc(0, 1'b0, 1'b1, 1'b0);
        idle(0, 5);
        pops(0, 5);
        do_reset();
        cyc(0, 1'b0, 1'b1, 1'b0);
        idle(0, 3);
        pops(0, 3);

        // Request while IDLE.
        do_reset();
        cyc(0, 1'b1, 1'b0, 1'b1);
        idle(0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
